// File: rtl/door_pkg.sv
// Shared constants for the door access sequencer.
//   DigitW      : width of one keypad digit
//   DefaultCode : factory access code, first digit in [15:12]
//   St*         : 3-bit FSM state encoding
//   code_digit  : extracts digit idx (0 = first) from a packed 4-digit code
//   max2        : elaboration-time maximum, used to size the shared timer
package door_pkg;

  localparam int unsigned DigitW = 4;
  localparam logic [4*DigitW-1:0] DefaultCode = 16'h1324;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StEntry   = 3'd1;
  localparam logic [2:0] StOpen    = 3'd2;
  localparam logic [2:0] StError   = 3'd3;
  localparam logic [2:0] StLockout = 3'd4;

  function automatic logic [DigitW-1:0] code_digit(input logic [4*DigitW-1:0] code,
                                                   input logic [1:0]          idx);
    logic [DigitW-1:0] d;
    case (idx)
      2'd0:    d = code[15:12];
      2'd1:    d = code[11:8];
      2'd2:    d = code[7:4];
      default: d = code[3:0];
    endcase
    return d;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/door_timer.sv
// Down-counter shared by all timed windows of the door sequencer.
//   clk_i      : clock, rising edge
//   reset_i    : asynchronous active-high reset, clears the count
//   load_i     : load load_val_i this cycle (takes priority over counting)
//   load_val_i : value to load
//   expired_o  : count is zero
// The counter stops at zero, so expired_o stays high until the next load.
module door_timer #(
  parameter int unsigned Width = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/door_access_ctrl.sv
// Door access sequencer: turns keypad codes into digit events, checks a
// 4-digit entry against CODE and times the open / error / lockout windows.
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset, returns to idle
//   btn      : keypad code, 0 = no key (debounced, synchronous to clk)
//   unlock   : lock actuator enable
//   green    : access-granted lamp
//   red      : error / lockout lamp
//   lockout  : keypad disabled
//   fail_cnt : consecutive failed entries, saturates at MAX_FAIL
module door_access_ctrl
  import door_pkg::*;
#(
  parameter logic [15:0] CODE           = DefaultCode,
  parameter int unsigned OPEN_CYCLES    = 8,
  parameter int unsigned ERR_CYCLES     = 4,
  parameter int unsigned LOCKOUT_CYCLES = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_FAIL       = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DigitW-1:0]               btn,
  output logic                            unlock,
  output logic                            green,
  output logic                            red,
  output logic                            lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam int unsigned MaxCycles = max2(max2(OPEN_CYCLES, ERR_CYCLES),
                                           max2(LOCKOUT_CYCLES, TIMEOUT_CYCLES));
  localparam int unsigned TW = $clog2(MaxCycles + 1);

  // Windows last exactly N cycles: load N-1 and leave on the cycle the count is zero.
  localparam logic [TW-1:0] OpenLoad    = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] ErrLoad     = TW'(ERR_CYCLES - 1);
  localparam logic [TW-1:0] LockLoad    = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] TimeoutLoad = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] MaxFail     = FW'(MAX_FAIL);

  logic [2:0]        state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic              match_q, match_d;
  logic [FW-1:0]     fail_q, fail_d, fail_inc;
  logic [DigitW-1:0] btn_q;
  logic              key_evt, dig_ok, entry_ok;
  logic              tmr_load, tmr_expired;
  logic [TW-1:0]     tmr_val;

  // A new non-zero code is one press; holding a key produces no further events.
  assign key_evt  = (btn != btn_q) && (btn != '0);
  // idx_q is 0 in idle, so one comparator serves both the first and later digits.
  assign dig_ok   = (btn == code_digit(CODE, idx_q));
  assign entry_ok = match_q && dig_ok;
  assign fail_inc = (fail_q < MaxFail) ? fail_q + 1'b1 : fail_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    match_d  = match_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_val  = TimeoutLoad;
    case (state_q)
      StIdle: begin
        if (key_evt) begin
          match_d  = dig_ok;
          idx_d    = 2'd1;
          state_d  = StEntry;
          tmr_load = 1'b1;
        end
      end
      StEntry: begin
        // A key event takes precedence over a timeout in the same cycle.
        if (key_evt) begin
          tmr_load = 1'b1;
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            if (entry_ok) begin
              state_d = StOpen;
              fail_d  = '0;
              tmr_val = OpenLoad;
            end else begin
              fail_d = fail_inc;
              if (fail_inc < MaxFail) begin
                state_d = StError;
                tmr_val = ErrLoad;
              end else begin
                state_d = StLockout;
                tmr_val = LockLoad;
              end
            end
          end else begin
            match_d = entry_ok;
            idx_d   = idx_q + 2'd1;
          end
        end else if (tmr_expired) begin
          state_d = StIdle;
          idx_d   = 2'd0;
        end
      end
      StOpen, StError: begin
        if (tmr_expired) state_d = StIdle;
      end
      StLockout: begin
        if (tmr_expired) begin
          state_d = StIdle;
          fail_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      match_q <= 1'b0;
      fail_q  <= '0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      fail_q  <= fail_d;
      btn_q   <= btn;
    end
  end

  door_timer #(
    .Width(TW)
  ) u_timer (
    .clk_i     (clk),
    .reset_i   (reset),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expired_o (tmr_expired)
  );

  always_comb begin
    unlock  = 1'b0;
    green   = 1'b0;
    red     = 1'b0;
    lockout = 1'b0;
    case (state_q)
      StOpen: begin
        unlock = 1'b1;
        green  = 1'b1;
      end
      StError: red = 1'b1;
      StLockout: begin
        red     = 1'b1;
        lockout = 1'b1;
      end
      default: ;
    endcase
  end

  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_door_access_ctrl.sv
module tb_door_access_ctrl;

  localparam int CodeInt = 'h1324;
  localparam int OpenN = 8, ErrN = 4, LockN = 32, ToN = 16, MaxF = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       unlock, green, red, lockout;
  logic [1:0] fail_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  door_access_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
    .unlock  (unlock),
    .green   (green),
    .red     (red),
    .lockout (lockout),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: digits typed so far, a countdown for the current
  // timed window and which window it is (0 none, 1 open, 2 error, 3 lockout).
  logic [3:0] m_digits[$];
  int         m_idle, m_window, m_kind, m_fail;
  logic [3:0] m_prev;

  task automatic model_clear();
    m_digits.delete();
    m_idle = 0; m_window = 0; m_kind = 0; m_fail = 0; m_prev = 4'd0;
  endtask

  task automatic finish_entry();
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (int'(m_digits[i]) != ((CodeInt >> (4 * (3 - i))) & 15)) ok = 1'b0;
    m_digits.delete();
    if (ok) begin
      m_kind = 1; m_window = OpenN; m_fail = 0;
    end else begin
      m_fail = (m_fail < MaxF) ? m_fail + 1 : MaxF;
      if (m_fail >= MaxF) begin m_kind = 3; m_window = LockN; end
      else begin m_kind = 2; m_window = ErrN; end
    end
  endtask

  task automatic model_step(input logic [3:0] b);
    bit evt;
    evt = (b != m_prev) && (b != 4'd0);
    m_prev = b;
    if (m_window > 0) begin
      m_window--;
      if (m_window == 0) begin
        if (m_kind == 3) m_fail = 0;
        m_kind = 0;
      end
    end else if (m_digits.size() > 0) begin
      if (evt) begin
        m_digits.push_back(b);
        m_idle = 0;
        if (m_digits.size() == 4) finish_entry();
      end else begin
        m_idle++;
        if (m_idle >= ToN) begin m_digits.delete(); m_idle = 0; end
      end
    end else if (evt) begin
      m_digits.push_back(b);
      m_idle = 0;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_clear();
    else model_step(btn);
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      n_vec++;
      if (unlock !== (m_kind == 1) || green !== (m_kind == 1) ||
          red !== (m_kind == 2 || m_kind == 3) || lockout !== (m_kind == 3) ||
          int'(fail_cnt) != m_fail) begin
        n_err++;
        $display("FAIL model t=%0t got u/g/r/l/f=%b%b%b%b/%0d exp %b%b%b%b/%0d", $time,
                 unlock, green, red, lockout, fail_cnt, m_kind == 1, m_kind == 1,
                 m_kind == 2 || m_kind == 3, m_kind == 3, m_fail);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0d exp %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] b);
    @(negedge clk);
    btn = b;
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'd0);
  endtask

  task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d);
    step(a); step(b); step(c); step(d);
  endtask

  // Called right after a negedge: reset asserted mid-cycle, outputs must drop at once.
  task automatic pulse_reset(input string name);
    #2 reset = 1'b1;
    #1;
    chk({name, "_outs"}, int'({unlock, green, red, lockout}), 0);
    chk({name, "_fail"}, int'(fail_cnt), 0);
    btn = 4'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int cnt_a, cnt_b;

  initial begin
    reset = 1'b1;
    btn   = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_outs", int'({unlock, green, red, lockout}), 0);
    chk("reset_fail", int'(fail_cnt), 0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // 1: correct code opens for exactly 8 cycles, one cycle after the 4th digit.
    idle(2);
    enter(1, 3, 2, 4);
    @(negedge clk);
    chk("t1_first_cycle", int'(unlock), 1);
    cnt_a = 1; cnt_b = int'(red);
    repeat (15) begin
      @(negedge clk); btn = 4'd0;
      cnt_a += int'(unlock); cnt_b += int'(red);
    end
    chk("t1_open_len", cnt_a, 8);
    chk("t1_no_red", cnt_b, 0);
    chk("t1_fail", int'(fail_cnt), 0);

    // 2: held 2 is one event; the extra 4 completes a wrong entry.
    idle(2);
    step(1); step(2); step(2); step(4); step(0); step(4);
    @(negedge clk);
    chk("t2_red_now", int'(red), 1);
    chk("t2_fail", int'(fail_cnt), 1);
    cnt_a = 1; cnt_b = int'(unlock);
    repeat (9) begin
      @(negedge clk); btn = 4'd0;
      cnt_a += int'(red); cnt_b += int'(unlock);
    end
    chk("t2_red_len", cnt_a, 4);
    chk("t2_no_unlock", cnt_b, 0);

    // 3: three wrong entries lock out for 32 cycles; keypad ignored meanwhile.
    pulse_reset("t3_pre");
    idle(2);
    for (int k = 0; k < 3; k++) begin
      enter(1, 3, 2, 1);
      if (k < 2) idle(6);
    end
    @(negedge clk);
    chk("t3_lockout_now", int'(lockout), 1);
    chk("t3_fail_sat", int'(fail_cnt), 3);
    cnt_a = 1; cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt_a += int'(lockout); cnt_b += int'(unlock);
      btn = (i == 0) ? 4'd1 : (i == 1) ? 4'd3 : (i == 2) ? 4'd2 : (i == 3) ? 4'd4 : 4'd0;
    end
    chk("t3_lock_len", cnt_a, 32);
    chk("t3_no_unlock", cnt_b, 0);
    chk("t3_fail_clear", int'(fail_cnt), 0);

    // 4: partial entry abandoned after 16 idle cycles; a fresh entry then opens.
    step(1); step(3);
    idle(16);
    enter(1, 3, 2, 4);
    @(negedge clk);
    chk("t4_open_after_timeout", int'(unlock), 1);
    idle(12);

    // 5: one failure, then a correct entry with the first key held 5 cycles.
    enter(1, 3, 2, 1);
    idle(6);
    chk("t5_fail_one", int'(fail_cnt), 1);
    repeat (5) step(1);
    step(3); step(2); step(4);
    @(negedge clk);
    chk("t5_open", int'(unlock), 1);
    chk("t5_fail_zero", int'(fail_cnt), 0);
    idle(12);

    // 6: reset mid-open and mid-entry; a following full entry opens normally.
    enter(1, 3, 2, 4);
    repeat (3) @(negedge clk);
    pulse_reset("t6_open");
    step(1); step(3);
    pulse_reset("t6_entry");
    enter(1, 3, 2, 4);
    @(negedge clk);
    chk("t6_reopen", int'(unlock), 1);
    idle(12);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        @(negedge clk);
        pulse_reset("rnd_reset");
      end else if (r < 10) begin
        step(0);
        enter(1, 3, 2, 4);
      end else if (r < 14) begin
        idle(20);
      end else begin
        step(4'($urandom_range(0, 4)));
      end
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
